mmio_bridge: RTL

Memory-mapped I/O slave on the CPU data-memory port, beside the data cache. It decodes the `0x8xxxxxxx` address region and provides a UART transmit holding register, a buffered UART receive FIFO, and cycle and retired-instruction counters. The CPU-facing side obeys the dcache timing contract, so the top level can mux `mmio_dout` into the CPU's load path.

---
 rtl/mmio_bridge_pkg.sv | 24 ++
 rtl/mmio_bridge_fifo_sync.sv | 54 +++++
 rtl/mmio_bridge.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: shared MMIO region tag, register offsets and decode helper.
package mmio_bridge_pkg;

  // Upper address nibble that selects the MMIO region.
  localparam logic [3:0] MMIO_REGION = 4'h8;

  // Register select taken from addr[4:2] (word offset inside the region).
  typedef enum logic [2:0] {
    MMIO_STATUS  = 3'd0,  // 0x00 R: {rx_nonempty, tx_empty}
    MMIO_RXDATA  = 3'd1,  // 0x04 R: RX FIFO head, pops
    MMIO_TXDATA  = 3'd2,  // 0x08 W: TX holding register
    MMIO_RSVD3   = 3'd3,  // 0x0C unmapped
    MMIO_CYCLE   = 3'd4,  // 0x10 R: cycle counter
    MMIO_INSTR   = 3'd5,  // 0x14 R: retired-instruction counter
    MMIO_CLEAR   = 3'd6,  // 0x18 W: clear both counters
    MMIO_RSVD7   = 3'd7   // 0x1C unmapped
  } mmio_reg_e;

  // True when the address lies in the MMIO region.
  function automatic logic mmio_region_hit(input logic [31:0] a);
    return (a[31:28] == MMIO_REGION);
  endfunction

endpackage

// File: rtl/mmio_bridge_fifo_sync.sv
// fifo_sync: parameterised synchronous FIFO with a combinational head output.
// Push is ignored when full, pop is ignored when empty; both may occur together.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == (AW+1)'(0));
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage write; contents need no reset because occupancy governs validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
      else                       r_count <= r_count;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: MMIO slave beside the dcache providing UART TX/RX and
// cycle/instruction counters with a one-cycle registered read path.
module mmio_bridge
  import mmio_bridge_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] din,
  input  logic        stall,
  input  logic        inst_retired,
  output logic        mmio_hit,
  output logic        mmio_rd_q,
  output logic [31:0] mmio_dout,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  logic        r_rd_q;
  logic [31:0] r_dout;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  logic        w_valid;
  logic        w_rd;
  logic        w_wr;
  mmio_reg_e   w_sel;
  logic        w_pop;
  logic        w_tx_drain;
  logic        w_tx_load;
  logic        w_clear;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [31:0] w_rd_data;
  logic        w_unused_bits;

  // Offset bits below the word and inside the region, plus upper write data, are don't-care.
  assign w_unused_bits = ^{addr[27:5], addr[1:0], din[31:8]};

  assign mmio_hit      = mmio_region_hit(addr);
  assign w_valid       = mmio_hit && !stall;
  assign w_sel         = mmio_reg_e'(addr[4:2]);
  assign w_rd          = w_valid && re;
  assign w_wr          = w_valid && (we != 4'h0);
  assign w_pop         = w_rd && (w_sel == MMIO_RXDATA) && !w_rx_empty;
  assign w_tx_drain    = r_tx_valid && uart_tx_ready;
  assign w_tx_load     = w_wr && (w_sel == MMIO_TXDATA) && (!r_tx_valid || w_tx_drain);
  assign w_clear       = w_wr && (w_sel == MMIO_CLEAR);

  // Held low during reset so no byte is accepted into a FIFO being flushed.
  assign uart_rx_ready = !w_rx_full && !reset;

  assign mmio_rd_q     = r_rd_q;
  assign mmio_dout     = r_dout;
  assign uart_tx_data  = r_tx_data;
  assign uart_tx_valid = r_tx_valid;

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_rx_valid && uart_rx_ready),
    .pop   (w_pop),
    .din   (uart_rx_data),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .head  (w_rx_head)
  );

  // Read mux: selects register contents as seen in the access cycle.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (w_sel)
      MMIO_STATUS: w_rd_data = {30'd0, !w_rx_empty, !r_tx_valid};
      MMIO_RXDATA: w_rd_data = w_rx_empty ? 32'h0000_0000 : {24'd0, w_rx_head};
      MMIO_CYCLE:  w_rd_data = r_cycle_cnt;
      MMIO_INSTR:  w_rd_data = r_instr_cnt;
      default:     w_rd_data = 32'h0000_0000;
    endcase
  end

  // Registered read response; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_q <= 1'b0;
      r_dout <= 32'h0000_0000;
    end else begin
      r_rd_q <= w_rd;
      if (w_rd) r_dout <= w_rd_data;
      else      r_dout <= r_dout;
    end
  end

  // TX holding register: a load wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_tx_load) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= din[7:0];
    end else if (w_tx_drain) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= r_tx_data;
    end else begin
      r_tx_valid <= r_tx_valid;
      r_tx_data  <= r_tx_data;
    end
  end

  // Free-running counters; a clear write overrides the increment.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_cycle_cnt <= 32'h0000_0000;
      r_instr_cnt <= 32'h0000_0000;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'h0000_0001;
      if (inst_retired) r_instr_cnt <= r_instr_cnt + 32'h0000_0001;
      else              r_instr_cnt <= r_instr_cnt;
    end
  end

endmodule
